io_uart_tx: RTL and testbench

IO_UART_TX -- requirements
Module: io_uart_tx

---
 rtl/io_uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/io_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_io_uart_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared types and constants for the
// memory-mapped UART transmitter.
package io_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_ALMST = 4;
  localparam int STAT_W     = 5;

  localparam logic [31:0] DEF_DATA_ADDR = 32'h0000_03fe;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_03fd;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push
// into a full FIFO is taken when a pop happens too.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: IO-mapped 8N1 transmitter with a byte
// FIFO, sticky overflow flag and a status register.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] out_data,
  input  logic        out_strobe,
  input  logic        in_strobe,
  output logic [31:0] in_data,
  output logic        in_rdy,
  output logic        tx,
  output logic        busy
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic          push_req;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          bit_end;
  logic          ovf_set;
  logic          rd_clr;
  logic [STAT_W-1:0] stat;
  logic          unused_hi;

  assign unused_hi = ^out_data[31:8];

  assign push_req = out_strobe && (io_addr == DATA_ADDR);
  assign rd_clr   = in_strobe && (io_addr == STAT_ADDR);
  assign ovf_set  = push_req && full && !pop;
  assign bit_end  = (cnt_q == DIV_M1);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .din_i   (out_data[7:0]),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign busy   = !empty || (state_q != ST_IDLE);
  assign tx     = tx_q;
  assign in_rdy = 1'b1;

  // status word assembly, zero for any other address
  always_comb begin
    stat              = '0;
    stat[STAT_BUSY]   = busy;
    stat[STAT_EMPTY]  = empty;
    stat[STAT_FULL]   = full;
    stat[STAT_OVF]    = ovf_q;
    stat[STAT_ALMST]  = (count == CW'(FIFO_DEPTH - 1));
    in_data           = '0;
    if (io_addr == STAT_ADDR) begin
      in_data[STAT_W-1:0] = stat;
    end
  end

  // sticky overflow: a new drop beats a clearing read
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (rd_clr) begin
      ovf_d = 1'b0;
    end
  end

  // frame sequencer; tx_d is the line level for the next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // state registers; reset forces the line high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: scoreboard bench; a line monitor
// decodes frames and checks them against queued bytes.
`timescale 1ns/1ps
module tb_io_uart_tx;

  localparam int DIV = 4;
  localparam logic [31:0] A_DATA = 32'h0000_03fe;
  localparam logic [31:0] A_STAT = 32'h0000_03fd;

  logic        clk;
  logic        rst_n;
  logic [31:0] io_addr;
  logic [31:0] out_data;
  logic        out_strobe;
  logic        in_strobe;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        tx;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] sb [$];
  int         start_cyc [$];

  bit         m_act = 0;
  int         m_t   = 0;
  logic [7:0] m_byte;

  io_uart_tx #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (4),
    .DATA_ADDR  (A_DATA),
    .STAT_ADDR  (A_STAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_addr    (io_addr),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // line monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_act = 0;
    end else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act = 1;
        m_t   = 0;
        start_cyc.push_back(cyc);
      end
    end else begin
      m_t++;
      if (m_t == DIV / 2) begin
        chk("start_bit", tx, 0);
      end
      if (m_t % DIV == 0) begin
        if (m_t / DIV <= 8) begin
          m_byte[m_t / DIV - 1] = tx;
        end else begin
          chk("stop_bit", tx, 1);
          chk("sb_avail", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            chk("byte", m_byte, sb.pop_front());
          end
          m_act = 0;
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a,
                    input logic [7:0] d,
                    input bit acc);
    @(negedge clk);
    io_addr    = a;
    out_data   = {24'h5a5a5a, d};
    out_strobe = 1'b1;
    if (acc) sb.push_back(d);
    @(posedge clk);
    #1;
    out_strobe = 1'b0;
    io_addr    = '0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input bit strb,
                    input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    io_addr   = a;
    in_strobe = strb;
    #1;
    chk(tag, in_data, exp);
    @(posedge clk);
    #1;
    in_strobe = 1'b0;
    io_addr   = '0;
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (busy && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    io_addr    = A_STAT;
    out_data   = '0;
    out_strobe = 1'b0;
    in_strobe  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stat", in_data, 32'h2);
    chk("rdy", in_rdy, 1);
    @(negedge clk);
    rst_n   = 1'b1;
    io_addr = '0;

    // single byte from idle
    wr(A_DATA, 8'hA5, 1);
    chk("e_tx", tx, 1);
    chk("e_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("e1_tx", tx, 0);
    wait_idle(400, n);
    chk("frame_len", n + 1, 41);
    chk("sb_drain1", sb.size(), 0);

    // burst of five, then overflow handling
    start_cyc.delete();
    for (int i = 1; i <= 5; i++) begin
      wr(A_DATA, 8'(i), 1);
    end
    wr(A_DATA, 8'h06, 0);
    rd(A_STAT, 1, 32'h0000000D, "ovf_rd1");
    rd(A_STAT, 1, 32'h00000005, "ovf_rd2");
    @(negedge clk);
    io_addr    = A_DATA;
    out_data   = 32'h07;
    out_strobe = 1'b1;
    in_strobe  = 1'b1;
    #1;
    chk("combo_rd", in_data, 0);
    @(posedge clk);
    #1;
    out_strobe = 1'b0;
    in_strobe  = 1'b0;
    io_addr    = '0;
    rd(A_STAT, 1, 32'h0000000D, "ovf_keep");
    rd(A_STAT, 0, 32'h00000005, "ovf_clr");
    repeat (42) @(posedge clk);
    rd(A_STAT, 0, 32'h00000011, "cnt_m1");
    wait_idle(1000, n);
    chk("idle2", busy, 0);
    chk("sb_drain2", sb.size(), 0);
    chk("n_frames", start_cyc.size(), 5);
    for (int i = 1; i < start_cyc.size(); i++) begin
      chk("gap", start_cyc[i] - start_cyc[i-1], 10 * DIV);
    end

    // reset during data bit 3
    wr(A_DATA, 8'h35, 1);
    repeat (18) @(posedge clk);
    #1;
    chk("b3_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    io_addr = A_STAT;
    #1;
    chk("post_busy", busy, 0);
    chk("post_stat", in_data, 32'h2);

    // foreign address write, data-address read
    wr(32'h0000_03ff, 8'h77, 0);
    chk("bad_wr_busy", busy, 0);
    rd(A_DATA, 1, 32'h0, "data_rd");
    rd(A_STAT, 0, 32'h2, "bad_stat");
    repeat (60) @(posedge clk);
    chk("quiet_tx", tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
